// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the layer sequencers: state encoding and default pass geometry.
package nn_ctrl_pkg;

    localparam int DEF_N_INPUTS = 784;
    localparam int DEF_IDX_W    = 10;
    localparam int DEF_LAT      = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    function automatic logic state_is_busy(input seq_state_t s);
        case (s)
            ST_CLEAR, ST_STREAM, ST_DRAIN: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/en_delay_line.sv
// Registered LAT-stage shift line for a single enable bit, with synchronous clear.
module en_delay_line #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] line_r;

    // Shift the enable one stage per cycle; clear empties every stage at once.
    always_ff @(posedge clk) begin
        if (clr) begin
            line_r <= '0;
        end else begin
            line_r[0] <= din;
            for (int i = 1; i < LAT; i++) begin
                line_r[i] <= line_r[i-1];
            end
        end
    end

    assign dout = line_r[LAT-1];

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer pass: clear the MAC bank, stream N_INPUTS
// operand pairs with src_valid back-pressure, drain the fetch pipe, pulse done.
module layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int LAT      = DEF_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             src_valid,
    input  logic             abort,
    output logic             push_en,
    output logic             mem_en,
    output logic             mac_en,
    output logic             dp_clr,
    output logic [IDX_W-1:0] idx,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = $clog2(LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    seq_state_t       state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             issue_s;
    logic             kill_s;
    logic             line_clr_s;

    assign issue_s    = (state_r == ST_STREAM) && src_valid;
    assign kill_s     = abort && (state_r != ST_IDLE);
    assign line_clr_s = reset || kill_s;

    // Next-state, element index and drain counter.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        if (kill_s) begin
            state_s = ST_IDLE;
            idx_s   = '0;
            cnt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_CLEAR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    state_s = ST_STREAM;
                    idx_s   = '0;
                end
                ST_STREAM: begin
                    if (issue_s && (idx_r == LAST_IDX)) begin
                        state_s = ST_DRAIN;
                        idx_s   = '0;
                        cnt_s   = CNT_W'(LAT - 1);
                    end else if (issue_s) begin
                        idx_s = idx_r + IDX_W'(1);
                    end else begin
                        idx_s = idx_r;
                    end
                end
                ST_DRAIN: begin
                    // The last issued element needs LAT cycles to reach the MACs.
                    if (cnt_r == CNT_W'(0)) begin
                        state_s = ST_DONE;
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    idx_s   = '0;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State, index and drain-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
        end
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        push_en = 1'b0;
        mem_en  = 1'b0;
        dp_clr  = 1'b0;
        done    = 1'b0;
        busy    = state_is_busy(state_r);
        case (state_r)
            ST_CLEAR:  dp_clr = 1'b1;
            ST_STREAM: begin
                push_en = issue_s;
                mem_en  = issue_s;
            end
            ST_DONE:   done = 1'b1;
            default: begin
                push_en = 1'b0;
                mem_en  = 1'b0;
            end
        endcase
    end

    assign idx = idx_r;

    en_delay_line #(
        .LAT (LAT)
    ) u_mac_dly (
        .clk  (clk),
        .clr  (line_clr_s),
        .din  (issue_s),
        .dout (mac_en)
    );

endmodule
